// File: rtl/polyshift_pkg.sv
// polyshift_pkg: shared types for the polyshift family.
//   shift_type_t : encoding of the shift_type_i port.
//   state_t      : control FSM states of the sequential right shifter.
package polyshift_pkg;

    typedef enum logic [1:0] {
        LOGIC            = 2'd0,
        ARITHMETIC       = 2'd1,
        DOUBLE_PRECISION = 2'd2,
        CYCLIC           = 2'd3
    } shift_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/polyshift_r_arg.sv
// polyshift_r_arg: combinational selector for the bits shifted in from the left
// by a right polyshift. The shifter works on {arg, d_i}; arg sits above d_i so
// that arg[0] lands next to d_i's MSB.
// Ports:
//   d_i          [WORD_WIDTH-1:0]  word being shifted
//   c_i          [WORD_WIDTH-2:0]  placing bits for DOUBLE_PRECISION
//   shift_type_i [1:0]             shift type (polyshift_pkg::shift_type_t)
//   arg_o        [WORD_WIDTH-2:0]  selected placing bits
module polyshift_r_arg
    import polyshift_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] d_i,
    input  logic [WORD_WIDTH-2:0] c_i,
    input  logic [1:0]            shift_type_i,
    output logic [WORD_WIDTH-2:0] arg_o
);

    always_comb begin
        arg_o = '0;
        unique case (shift_type_t'(shift_type_i))
            LOGIC:            arg_o = '0;
            ARITHMETIC:       arg_o = {(WORD_WIDTH-1){d_i[WORD_WIDTH-1]}};
            DOUBLE_PRECISION: arg_o = c_i;
            // Low bits of d_i re-enter from the top: rotate right.
            CYCLIC:           arg_o = d_i[WORD_WIDTH-2:0];
            default:          arg_o = '0;
        endcase
    end

endmodule

// File: rtl/polyshift_r_seq.sv
// polyshift_r_seq: multi-cycle iterative barrel right shifter (LOGIC,
// ARITHMETIC, DOUBLE_PRECISION, CYCLIC). One shift_size bit is resolved per
// cycle, LSB first, behind valid/ready handshakes on both sides.
// Result: d_o = low WORD_WIDTH bits of ({arg, d_i} >> shift_size_i).
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i/ready_o  request handshake (inputs sampled on the accept edge only)
//   c_i, d_i, shift_size_i, shift_type_i  request operands
//   valid_o/ready_i  result handshake
//   d_o            registered result, held in IDLE
// Build option: define POLYSHIFT_R_SEQ_EARLY_EXIT_EN to leave SHIFT as soon as
// no higher shift_size bits remain (shift_size 0 goes straight to DONE).
module polyshift_r_seq
    import polyshift_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WORD_WIDTH-2:0]         c_i,
    input  logic [WORD_WIDTH-1:0]         d_i,
    input  logic [$clog2(WORD_WIDTH)-1:0] shift_size_i,
    input  logic [1:0]                    shift_type_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [WORD_WIDTH-1:0]         d_o
);

    localparam int unsigned STAGES = $clog2(WORD_WIDTH);
    localparam int unsigned EXT_W  = 2 * WORD_WIDTH - 1;
    localparam int unsigned IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

    state_t                  state_q, state_d;
    logic [EXT_W-1:0]        ext_q, ext_d;
    logic [STAGES-1:0]       amt_q, amt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_WIDTH-1:0]   dout_q, dout_d;

    logic [WORD_WIDTH-2:0]   arg;
    logic [EXT_W-1:0]        ext_stage;
    logic                    last_stage;

    polyshift_r_arg #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_arg (
        .d_i          (d_i),
        .c_i          (c_i),
        .shift_type_i (shift_type_i),
        .arg_o        (arg)
    );

    // Stage idx shifts by 2^idx. Total shift <= WORD_WIDTH-1, so the zero fill
    // from the top never reaches the result bits.
    assign ext_stage = amt_q[idx_q] ? (ext_q >> (1 << idx_q)) : ext_q;

`ifdef POLYSHIFT_R_SEQ_EARLY_EXIT_EN
    // Done once no amt bits above the current stage remain set.
    assign last_stage = (idx_q == IDX_W'(STAGES - 1)) || (((amt_q >> idx_q) >> 1) == '0);
`else
    assign last_stage = (idx_q == IDX_W'(STAGES - 1));
`endif

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        amt_d   = amt_q;
        idx_d   = idx_q;
        dout_d  = dout_q;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    ext_d   = {arg, d_i};
                    amt_d   = shift_size_i;
                    idx_d   = '0;
                    state_d = SHIFT;
`ifdef POLYSHIFT_R_SEQ_EARLY_EXIT_EN
                    if (shift_size_i == '0) begin
                        dout_d  = d_i;
                        state_d = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                ext_d = ext_stage;
                idx_d = idx_q + 1'b1;
                if (last_stage) begin
                    dout_d  = ext_stage[WORD_WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ext_q   <= '0;
            amt_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            amt_q   <= amt_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign d_o     = dout_q;

endmodule

// File: tb/tb_polyshift_r_seq.sv
// tb_polyshift_r_seq: directed self-checking bench for polyshift_r_seq with
// WORD_WIDTH=8. Expected results and latencies are hand-computed constants.
module tb_polyshift_r_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         valid_in;
    logic         ready_out;
    logic [W-2:0] c_in;
    logic [W-1:0] d_in;
    logic [2:0]   n_in;
    logic [1:0]   t_in;
    logic         valid_out;
    logic         ready_in;
    logic [W-1:0] d_out;

    int n_tests;
    int n_fail;

    polyshift_r_seq #(
        .WORD_WIDTH (W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid_in),
        .ready_o      (ready_out),
        .c_i          (c_in),
        .d_i          (d_in),
        .shift_size_i (n_in),
        .shift_type_i (t_in),
        .valid_o      (valid_out),
        .ready_i      (ready_in),
        .d_o          (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Number of SHIFT cycles between the accept edge and valid_o.
    function automatic int exp_lat(input logic [2:0] n);
`ifdef POLYSHIFT_R_SEQ_EARLY_EXIT_EN
        if (n[2]) return 3;
        if (n[1]) return 2;
        if (n[0]) return 1;
        return 0;
`else
        return 3;
`endif
    endfunction

    // Present a request and step through its accept edge; afterwards the
    // inputs are scrambled to show they are sampled only on that edge.
    task automatic accept(input string tag, input logic [W-2:0] c, input logic [W-1:0] d,
                          input logic [2:0] n, input logic [1:0] t);
        check({tag, "_ready_idle"}, 32'(ready_out), 32'd1);
        c_in     = c;
        d_in     = d;
        n_in     = n;
        t_in     = t;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        c_in     = ~c;
        d_in     = ~d;
        n_in     = ~n;
        t_in     = ~t;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int cnt;
        cnt = 0;
        while (!valid_out && cnt < 20) begin
            check({tag, "_busy_ready"}, 32'(ready_out), 32'd0);
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(lat));
        check({tag, "_valid"}, 32'(valid_out), 32'd1);
        check({tag, "_ready_done"}, 32'(ready_out), 32'd0);
    endtask

    task automatic release_result(input string tag);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        check({tag, "_valid_after"}, 32'(valid_out), 32'd0);
        check({tag, "_ready_after"}, 32'(ready_out), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-2:0] c, input logic [W-1:0] d,
                          input logic [2:0] n, input logic [1:0] t, input logic [W-1:0] exp);
        accept(tag, c, d, n, t);
        wait_done(tag, exp_lat(n));
        check({tag, "_d"}, 32'(d_out), 32'(exp));
        release_result(tag);
        check({tag, "_d_hold_idle"}, 32'(d_out), 32'(exp));
    endtask

    logic [W-1:0] held;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        c_in     = '0;
        d_in     = '0;
        n_in     = '0;
        t_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_d", 32'(d_out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Type codes: 0 LOGIC, 1 ARITHMETIC, 2 DOUBLE_PRECISION, 3 CYCLIC.
        run_op("logic_b4_3", 7'h00, 8'hB4, 3'd3, 2'd0, 8'h16);
        run_op("arith_b4_3", 7'h00, 8'hB4, 3'd3, 2'd1, 8'hF6);
        run_op("arith_34_7", 7'h00, 8'h34, 3'd7, 2'd1, 8'h00);
        run_op("arith_80_1", 7'h7F, 8'h80, 3'd1, 2'd1, 8'hC0);
        run_op("dp_55_0f_4", 7'h55, 8'h0F, 3'd4, 2'd2, 8'h50);
        run_op("cyc_81_1",   7'h00, 8'h81, 3'd1, 2'd3, 8'hC0);
        run_op("cyc_81_0",   7'h00, 8'h81, 3'd0, 2'd3, 8'h81);
        run_op("cyc_81_4",   7'h00, 8'h81, 3'd4, 2'd3, 8'h18);
        run_op("logic_a5_0", 7'h00, 8'hA5, 3'd0, 2'd0, 8'hA5);
        run_op("logic_ff_2", 7'h00, 8'hFF, 3'd2, 2'd0, 8'h3F);

        // Backpressure: result held while ready_i is low; new requests ignored.
        accept("bp", 7'h00, 8'h3C, 3'd2, 2'd0);
        wait_done("bp", exp_lat(3'd2));
        check("bp_d", 32'(d_out), 32'h0F);
        held     = d_out;
        valid_in = 1'b1;
        d_in     = 8'hFF;
        n_in     = 3'd0;
        t_in     = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(valid_out), 32'd1);
            check("bp_hold_d", 32'(d_out), 32'(held));
            check("bp_hold_ready", 32'(ready_out), 32'd0);
        end
        valid_in = 1'b0;
        release_result("bp");
        check("bp_no_new", 32'(valid_out), 32'd0);
        run_op("bp_next", 7'h00, 8'hC3, 3'd1, 2'd3, 8'hE1);

        // Reset in the middle of SHIFT; d_o currently holds 0xE1.
        accept("rst_mid", 7'h00, 8'h81, 3'd3, 2'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(valid_out), 32'd0);
        check("rst_mid_ready", 32'(ready_out), 32'd1);
        check("rst_mid_d", 32'(d_out), 32'd0);
        #1;
        rst = 1'b0;
        run_op("after_rst", 7'h00, 8'hF0, 3'd4, 2'd0, 8'h0F);

        // Reset while waiting in DONE.
        accept("rst_done", 7'h00, 8'h40, 3'd1, 2'd0);
        wait_done("rst_done", exp_lat(3'd1));
        check("rst_done_d", 32'(d_out), 32'h20);
        #2;
        rst = 1'b1;
        #1;
        check("rst_done_valid", 32'(valid_out), 32'd0);
        check("rst_done_dz", 32'(d_out), 32'd0);
        #1;
        rst = 1'b0;
        run_op("final", 7'h00, 8'h96, 3'd7, 2'd3, 8'h2D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
